// File: rtl/conv_2d_feeder_pkg.sv
// Shared types and constants for the conv_2d_feeder sequencer.
// Provides the FSM state enum, the lane count and a lane-slice helper.
package conv_pkg;

    localparam int LANES  = 4;
    localparam int DW     = 8;
    localparam int PSUM_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    function automatic logic signed [PSUM_W-1:0] psum_lane(
        input logic [LANES*PSUM_W-1:0] v,
        input int                      n
    );
        return v[n*PSUM_W +: PSUM_W];
    endfunction

endpackage

// File: rtl/conv_2d_feeder_addr_gen.sv
// Tap counter (ky, kx) and image/weight RAM address arithmetic for one job.
// Addresses wrap modulo 2^ADDR_W; window bounds are deliberately unchecked.
module conv_addr_gen #(
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] row,
    input  logic [ADDR_W-1:0] col,
    input  logic              step,
    output logic              last_tap,
    output logic [ADDR_W-1:0] x_addr,
    output logic [ADDR_W-1:0] w_addr
);
    import conv_pkg::*;

    localparam int KW = (K > 1) ? $clog2(K) : 1;

    logic [KW-1:0]     ky_reg;
    logic [KW-1:0]     kx_reg;
    logic [ADDR_W-1:0] row_reg;
    logic [ADDR_W-1:0] col_reg;
    logic [ADDR_W-1:0] ky_ext;
    logic [ADDR_W-1:0] kx_ext;

    assign last_tap = (ky_reg == KW'(K-1)) && (kx_reg == KW'(K-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ky_reg  <= '0;
            kx_reg  <= '0;
            row_reg <= '0;
            col_reg <= '0;
        end else if (load) begin
            ky_reg  <= '0;
            kx_reg  <= '0;
            row_reg <= row;
            col_reg <= col;
        end else if (step) begin
            // Row-major walk; the final tap wraps the counter back to (0,0).
            if (kx_reg == KW'(K-1)) begin
                kx_reg <= '0;
                ky_reg <= last_tap ? '0 : ky_reg + 1'b1;
            end else begin
                kx_reg <= kx_reg + 1'b1;
            end
        end
    end

    assign ky_ext = {{(ADDR_W-KW){1'b0}}, ky_reg};
    assign kx_ext = {{(ADDR_W-KW){1'b0}}, kx_reg};
    assign x_addr = (row_reg + ky_ext) * ADDR_W'(IMG_W) + (col_reg + kx_ext);
    assign w_addr = ky_ext * ADDR_W'(K) + kx_ext;

endmodule

// File: rtl/conv_2d_feeder.sv
// Job sequencer for the 4-lane conv_2d_engine: clear, feed K*K taps, drain, present result.
// Define CONV_FEEDER_RELU_EN to clamp negative result lanes to zero at capture.
module conv_2d_feeder #(
    parameter int K       = 3,
    parameter int IMG_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int DW      = 8,
    parameter int PSUM_W  = 16,
    parameter int ENG_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   out_row,
    input  logic [ADDR_W-1:0]   out_col,
    output logic                busy,
    output logic                x_rd_en,
    output logic [ADDR_W-1:0]   x_addr,
    input  logic [DW-1:0]       x_rdata,
    output logic                w_rd_en,
    output logic [ADDR_W-1:0]   w_addr,
    input  logic [4*DW-1:0]     w_rdata,
    output logic                eng_clear,
    output logic                eng_valid,
    output logic [DW-1:0]       eng_x,
    output logic [4*DW-1:0]     eng_w,
    input  logic [4*PSUM_W-1:0] eng_out,
    output logic [4*PSUM_W-1:0] res_data,
    output logic                res_valid,
    input  logic                res_ready
);
    import conv_pkg::*;

    localparam int DCW = (ENG_LAT > 0) ? $clog2(ENG_LAT + 1) : 1;

    state_t               state_reg;
    state_t               state_next;
    logic [DCW-1:0]       drain_reg;
    logic                 eng_valid_reg;
    logic                 res_valid_reg;
    logic [4*PSUM_W-1:0]  res_data_reg;
    logic [4*PSUM_W-1:0]  capture_next;
    logic                 load;
    logic                 feed;
    logic                 last_tap;
    logic                 drain_done;
    logic [ADDR_W-1:0]    gen_x_addr;
    logic [ADDR_W-1:0]    gen_w_addr;

    conv_addr_gen #(
        .K      (K),
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .row      (out_row),
        .col      (out_col),
        .step     (feed),
        .last_tap (last_tap),
        .x_addr   (gen_x_addr),
        .w_addr   (gen_w_addr)
    );

    assign drain_done = (state_reg == DRAIN) && (drain_reg == DCW'(ENG_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = FEED;
            FEED:    if (last_tap) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = OUT;
            OUT:     if (res_valid_reg && res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        load      = (state_reg == IDLE) && start;
        feed      = (state_reg == FEED);
        eng_clear = (state_reg == CLEAR);
    end

    assign x_rd_en = feed;
    assign w_rd_en = feed;
    assign x_addr  = feed ? gen_x_addr : '0;
    assign w_addr  = feed ? gen_w_addr : '0;

    // One register stage matches the one-cycle read latency of both RAMs.
    assign eng_valid = eng_valid_reg;
    assign eng_x     = eng_valid_reg ? x_rdata : '0;
    assign eng_w     = eng_valid_reg ? w_rdata : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [PSUM_W-1:0] lane;
            assign lane = eng_out[gi*PSUM_W +: PSUM_W];
`ifdef CONV_FEEDER_RELU_EN
            assign capture_next[gi*PSUM_W +: PSUM_W] = lane[PSUM_W-1] ? '0 : lane;
`else
            assign capture_next[gi*PSUM_W +: PSUM_W] = lane;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_valid_reg <= 1'b0;
            drain_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            eng_valid_reg <= feed;
            // DRAIN is entered alongside the last eng_valid cycle, so ENG_LAT
            // further cycles leave the engine output settled.
            drain_reg     <= (state_reg == DRAIN) ? drain_reg + 1'b1 : '0;
            if (drain_done) begin
                res_data_reg  <= capture_next;
                res_valid_reg <= 1'b1;
            end else if (res_valid_reg && res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;

endmodule

// File: tb/tb_conv_2d_feeder.sv
// Directed bench for conv_2d_feeder with behavioural image/weight RAMs and a 4-lane engine.
// Expected values are hand-computed; CONV_FEEDER_RELU_EN changes the negative-lane expectation.
module tb_conv_2d_feeder;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  out_row = '0;
    logic [7:0]  out_col = '0;
    logic        busy;
    logic        x_rd_en;
    logic [7:0]  x_addr;
    logic [7:0]  x_rdata = '0;
    logic        w_rd_en;
    logic [7:0]  w_addr;
    logic [31:0] w_rdata = '0;
    logic        eng_clear;
    logic        eng_valid;
    logic [7:0]  eng_x;
    logic [31:0] eng_w;
    logic [63:0] eng_out;
    logic [63:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]         img  [0:255];
    logic [31:0]        wram [0:255];
    logic signed [15:0] acc  [0:3];

    // Monitor state
    int   n_clear, n_valid, n_xrd, n_hs, lag_err, early_valid;
    logic prev_rd;
    logic seen_clear;
    logic [7:0] xq [$];
    logic [7:0] wq [$];

    conv_2d_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .x_rd_en   (x_rd_en),
        .x_addr    (x_addr),
        .x_rdata   (x_rdata),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .w_rdata   (w_rdata),
        .eng_clear (eng_clear),
        .eng_valid (eng_valid),
        .eng_x     (eng_x),
        .eng_w     (eng_w),
        .eng_out   (eng_out),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (x_rd_en) x_rdata <= img[x_addr];
        if (w_rd_en) w_rdata <= wram[w_addr];
    end

    // Engine accumulators are not reset by rst_n; only eng_clear zeroes them.
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (eng_clear)
                acc[n] <= '0;
            else if (eng_valid)
                acc[n] <= acc[n] + $signed(eng_x) * $signed(eng_w[n*8 +: 8]);
        end
    end
    assign eng_out = {acc[3], acc[2], acc[1], acc[0]};

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd <= 1'b0;
        end else begin
            if (eng_clear) begin
                n_clear    <= n_clear + 1;
                seen_clear <= 1'b1;
            end
            if (eng_valid) begin
                n_valid <= n_valid + 1;
                if (!seen_clear) early_valid <= early_valid + 1;
            end
            if (x_rd_en) begin
                n_xrd <= n_xrd + 1;
                xq.push_back(x_addr);
                wq.push_back(w_addr);
            end
            if (res_valid && res_ready) n_hs <= n_hs + 1;
            if (eng_valid != prev_rd) lag_err <= lag_err + 1;
            prev_rd <= x_rd_en;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        n_clear = 0; n_valid = 0; n_xrd = 0; n_hs = 0;
        lag_err = 0; early_valid = 0; seen_clear = 1'b0;
        xq.delete(); wq.delete();
    endtask

    task automatic fill(input logic [7:0] xv, input logic [31:0] wv);
        for (int i = 0; i < 256; i++) begin
            img[i]  = xv;
            wram[i] = wv;
        end
    endtask

    // Launch one job and wait for res_valid; lat counts edges after the accept edge.
    task automatic launch(input logic [7:0] r, input logic [7:0] c, output int lat);
        mon_clear();
        @(posedge clk); #1;
        start = 1'b1; out_row = r; out_col = c;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, res_valid, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_lanes(input string tag, input longint l0, input longint l1,
                               input longint l2, input longint l3);
        check_eq({tag, "_lane0"}, psum_lane(res_data, 0), l0);
        check_eq({tag, "_lane1"}, psum_lane(res_data, 1), l1);
        check_eq({tag, "_lane2"}, psum_lane(res_data, 2), l2);
        check_eq({tag, "_lane3"}, psum_lane(res_data, 3), l3);
    endtask

    int           lat;
    logic [63:0]  held;
    logic [7:0]   exp_x [9];
    longint       neg_lane;

    initial begin
        exp_x = '{10, 11, 12, 18, 19, 20, 26, 27, 28};
`ifdef CONV_FEEDER_RELU_EN
        neg_lane = 0;
`else
        neg_lane = -9;
`endif
        for (int n = 0; n < 4; n++) acc[n] = 16'sh1234;
        fill(8'd1, {8'd0, 8'hFF, 8'd2, 8'd1});
        mon_clear();

        // Reset state
        #3;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_eng_clear", eng_clear, 0);
        check_eq("rst_eng_valid", eng_valid, 0);
        check_eq("rst_x_rd_en", x_rd_en, 0);
        #9 rst_n = 1'b1;

        // Uniform data: lanes 9, 18, -9, 0
        launch(8'd0, 8'd0, lat);
        check_eq("uni_latency", lat, 12);
        check_lanes("uni", 9, 18, neg_lane, 0);
        check_eq("uni_clears", n_clear, 1);
        check_eq("uni_valids", n_valid, 9);
        check_eq("uni_lag", lag_err, 0);
        handshake("uni");

        // Address order for row=1, col=2
        launch(8'd1, 8'd2, lat);
        check_eq("addr_reads", xq.size(), 9);
        for (int i = 0; i < 9 && i < xq.size(); i++) begin
            check_eq($sformatf("x_addr%0d", i), xq[i], exp_x[i]);
            check_eq($sformatf("w_addr%0d", i), wq[i], i);
        end
        check_eq("addr_valids", n_valid, 9);
        check_eq("addr_lag", lag_err, 0);
        handshake("addr");

        // Backpressure with an ignored start pulse
        launch(8'd0, 8'd0, lat);
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(posedge clk); #1;
            check_eq($sformatf("bp_stable%0d", i), res_data, held);
            check_eq($sformatf("bp_busy%0d", i), busy, 1);
            check_eq($sformatf("bp_valid%0d", i), res_valid, 1);
        end
        start = 1'b0;
        check_eq("bp_no_reads", n_xrd, 9);
        handshake("bp");
        @(posedge clk); #1;
        check_eq("bp_no_restart", busy, 0);

        // Back-to-back: start and res_ready held high
        mon_clear();
        @(posedge clk); #1;
        start = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 42; i++) @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_eq("b2b_clears", n_clear, 3);
        check_eq("b2b_handshakes", n_hs, 3);
        check_eq("b2b_valids", n_valid, 27);
        check_eq("b2b_lane1", psum_lane(res_data, 1), 18);
        @(posedge clk); #1;
        check_eq("b2b_idle", busy, 0);

        // Reset during tap 4
        mon_clear();
        @(posedge clk); #1;
        start = 1'b1; out_row = 8'd0; out_col = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_pre_rd", x_rd_en, 1);
        check_eq("mid_pre_waddr", w_addr, 4);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_busy", busy, 0);
        check_eq("mid_x_rd_en", x_rd_en, 0);
        check_eq("mid_w_rd_en", w_rd_en, 0);
        check_eq("mid_x_addr", x_addr, 0);
        check_eq("mid_w_addr", w_addr, 0);
        check_eq("mid_eng_valid", eng_valid, 0);
        check_eq("mid_eng_x", eng_x, 0);
        check_eq("mid_eng_w", eng_w, 0);
        check_eq("mid_eng_clear", eng_clear, 0);
        check_eq("mid_res_valid", res_valid, 0);
        #4 rst_n = 1'b1;

        // Signed extremes after reset: 9 * 16384 wraps to 16384
        fill(8'h80, 32'h80808080);
        launch(8'd3, 8'd3, lat);
        check_eq("ext_latency", lat, 12);
        check_lanes("ext", 16384, 16384, 16384, 16384);
        check_eq("ext_early_valid", early_valid, 0);
        check_eq("ext_clears", n_clear, 1);
        check_eq("ext_valids", n_valid, 9);
        handshake("ext");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
